// File: rtl/pet2001_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pet2001_pkg
//  Description : Shared constants and types for the PS/2 to PET 2001 key
//                matrix converter: PS/2 special codes, matrix geometry,
//                key position record and receiver state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pet2001_pkg;

   // PS/2 prefix codes
   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;

   // PS/2 status/response codes that never reach the matrix
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   localparam int PET_ROWS = 10;

   typedef struct packed {
      logic       valid;
      logic [3:0] row;
      logic [2:0] col;
   } key_pos_t;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_t;

   // Codes the decoder drops without touching the prefix flags
   function automatic logic is_ignored(input logic [7:0] code);
      return (code == PS2_BAT_OK) || (code == PS2_ACK)    || (code == PS2_ECHO) ||
             (code == PS2_RESEND) || (code == PS2_ERR0)   || (code == PS2_ERR1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pet2001ps2_key_if.sv
`default_nettype none
// ============================================================================
//  Module      : pet2001ps2_key_if
//  Description : Keyboard port between the PS/2 converter (slave) and the
//                PIA1 side (master): row select in, column byte and key
//                event pulse out.
//  Revision    : 1.0  initial release
// ============================================================================
interface pet2001ps2_key_if;
   logic [3:0] keyrow;
   logic [7:0] keyin;
   logic       key_event;

   modport master (output keyrow, input keyin, input key_event);
   modport slave  (input keyrow, output keyin, output key_event);
endinterface
`default_nettype wire

// File: rtl/pet2001ps2_keymap.sv
`default_nettype none
// ============================================================================
//  Module      : pet2001ps2_keymap
//  Description : Combinational ROM translating {ext, scan code} into a PET
//                matrix position. Codes not in the table return valid=0.
//  Revision    : 1.0  initial release
// ============================================================================
module pet2001ps2_keymap
   import pet2001_pkg::*;
(
   input  wire logic [8:0] key_i,
   output key_pos_t        pos_o
);

   function automatic key_pos_t kp(input int unsigned row, input int unsigned col);
      kp.valid = 1'b1;
      kp.row   = 4'(row);
      kp.col   = 3'(col);
   endfunction

   // Table lookup; bit 8 is the E0 prefix
   always_comb begin
      pos_o = '0;
      case (key_i)
         9'h01C:  pos_o = kp(4, 0);   // A
         9'h012:  pos_o = kp(8, 0);   // left shift
         9'h059:  pos_o = kp(8, 5);   // right shift
         9'h05A:  pos_o = kp(6, 5);   // RETURN
         9'h029:  pos_o = kp(9, 2);   // space
         9'h076:  pos_o = kp(9, 4);   // RUN/STOP
         9'h066:  pos_o = kp(1, 7);   // DEL
         9'h175:  pos_o = kp(1, 0);   // cursor up/down
         9'h174:  pos_o = kp(0, 7);   // cursor left/right
         default: pos_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pet2001ps2_key.sv
`default_nettype none
// ============================================================================
//  Module      : pet2001ps2_key
//  Description : PS/2 keyboard to PET 2001 10x8 key matrix. Conditions the
//                PS/2 lines, receives frames, decodes E0/F0 make/break codes
//                and presents the active-low column byte for the row chosen
//                by PIA1 port A.
//                Optional macro PET2001_PS2_PARITY_EN: reject frames whose
//                odd parity check fails.
//  Revision    : 1.0  initial release
// ============================================================================
module pet2001ps2_key
   import pet2001_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
)(
   input  wire logic         clk,
   input  wire logic         reset_n,
   input  wire logic         ps2_clk,
   input  wire logic         ps2_data,
   pet2001ps2_key_if.slave   kb
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [1:0]            rst_sync_q;
   logic                  rst_n_w;
   logic [1:0]            ps2c_sync_q, ps2d_sync_q;
   logic                  filt_q, filt_d;
   logic [7:0]            filt_cnt_q, filt_cnt_d;
   logic                  sample_w, data_w, timeout_w, par_ok_w, par_odd_w;
   rx_state_t             state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shift_q, shift_d, code_q, code_d;
   logic                  par_q, par_d, code_valid_q, code_valid_d;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
   logic                  ext_q, ext_d, brk_q, brk_d;
   logic [PET_ROWS-1:0][7:0] matrix_q, matrix_d;
   logic [7:0]            keyin_q, keyin_d;
   logic                  key_event_q, key_event_d;
   key_pos_t              pos_w;

   // Reset asserts immediately, releases two clocks later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_w = rst_sync_q[1];

   // Two-flop synchronisers plus glitch filter state; lines idle high
   always_ff @(posedge clk or negedge rst_n_w) begin
      if (!rst_n_w) begin
         ps2c_sync_q <= 2'b11;
         ps2d_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
      end else begin
         ps2c_sync_q <= {ps2c_sync_q[0], ps2_clk};
         ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
      end
   end

   // Filtered level follows only after FILTER_LEN consecutive differing samples
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (ps2c_sync_q[1] != filt_q) begin
         if (filt_cnt_q == 8'(FILTER_LEN - 1)) filt_d = ps2c_sync_q[1];
         else                                  filt_cnt_d = filt_cnt_q + 8'd1;
      end
   end

   assign sample_w  = filt_q & ~filt_d;
   assign data_w    = ps2d_sync_q[1];
   assign timeout_w = (state_q != RX_IDLE) && !sample_w &&
                      (to_cnt_q == TO_W'(TIMEOUT - 1));
   assign par_odd_w = ^{shift_q, par_q};
`ifdef PET2001_PS2_PARITY_EN
   assign par_ok_w  = par_odd_w;
`else
   // Parity is captured for observability but never enforced
   assign par_ok_w  = par_odd_w | 1'b1;
`endif

   // Receiver and timeout state registers
   always_ff @(posedge clk or negedge rst_n_w) begin
      if (!rst_n_w) begin
         state_q      <= RX_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   // Frame receiver: start, 8 data LSB first, parity, stop
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      to_cnt_d     = (state_q == RX_IDLE || sample_w) ? '0 : to_cnt_q + TO_W'(1);
      if (timeout_w) begin
         state_d = RX_IDLE;
      end else if (sample_w) begin
         case (state_q)
            RX_IDLE: begin
               if (!data_w) begin
                  state_d   = RX_DATA;
                  bit_cnt_d = '0;
               end
            end
            RX_DATA: begin
               shift_d   = {data_w, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
            end
            RX_PARITY: begin
               par_d   = data_w;
               state_d = RX_STOP;
            end
            RX_STOP: begin
               state_d = RX_IDLE;
               if (data_w && par_ok_w) begin
                  code_valid_d = 1'b1;
                  code_d       = shift_q;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   pet2001ps2_keymap u_keymap (
      .key_i (({ext_q, code_q})),
      .pos_o (pos_w)
   );

   // Decoder, matrix and output registers
   always_ff @(posedge clk or negedge rst_n_w) begin
      if (!rst_n_w) begin
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         matrix_q    <= '0;
         keyin_q     <= 8'hFF;
         key_event_q <= 1'b0;
      end else begin
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         matrix_q    <= matrix_d;
         keyin_q     <= keyin_d;
         key_event_q <= key_event_d;
      end
   end

   // Prefix tracking, matrix update and row readout of the updated matrix
   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      matrix_d    = matrix_q;
      key_event_d = 1'b0;
      if (timeout_w) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (code_valid_q) begin
         if (code_q == PS2_BREAK) begin
            brk_d = 1'b1;
         end else if (code_q == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (!is_ignored(code_q)) begin
            if (pos_w.valid) begin
               matrix_d[pos_w.row][pos_w.col] = ~brk_q;
               key_event_d = 1'b1;
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
      keyin_d = 8'hFF;
      if (kb.keyrow < 4'(PET_ROWS)) keyin_d = ~matrix_d[kb.keyrow];
   end

   assign kb.keyin     = keyin_q;
   assign kb.key_event = key_event_q;

endmodule
`default_nettype wire

// File: tb/tb_pet2001ps2_key.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pet2001ps2_key
//  Description : Self-checking bench for pet2001ps2_key. Expected column
//                bytes are queued as frames are sent and popped on each
//                key_event pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pet2001ps2_key;

   localparam int FILT = 8;
   localparam int TO   = 1000;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   logic [7:0] mdl [16];

   pet2001ps2_key_if kb();

   pet2001ps2_key #(.FILTER_LEN(FILT), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kb       (kb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_row(input int r);
      return (r < 10) ? ~mdl[r] : 8'hFF;
   endfunction

   // Update the model and queue the column byte expected at the event pulse
   task automatic expect_key(input int r, input int c, input logic pressed);
      mdl[r][c] = pressed;
      exp_q.push_back(exp_row(r));
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_clk(20);
      ps2_clk = 1'b0;
      wait_clk(20);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par);
      logic par;
      par = ~^code ^ bad_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(code[i]);
      send_bit(par);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_clk(30);
   endtask

   task automatic check_row(input string tag, input int r);
      kb.keyrow = 4'(r);
      wait_clk(2);
      chk(tag, kb.keyin, exp_row(r));
   endtask

   task automatic check_drained(input string tag);
      chk(tag, exp_q.size(), 0);
   endtask

   // Scoreboard: every key_event pulse must match the oldest queued byte
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && kb.key_event === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_key_event", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("event_keyin", kb.keyin, e);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
      kb.keyrow = 4'd0;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(4);

      // Reset state across every row select
      for (int r = 0; r < 16; r++) begin
         kb.keyrow = 4'(r);
         wait_clk(2);
         chk("reset_keyin", kb.keyin, 8'hFF);
         chk("reset_key_event", kb.key_event, 1'b0);
      end

      // Press and release A
      kb.keyrow = 4'd4;
      expect_key(4, 0, 1'b1);
      send_frame(8'h1C, 1'b0);
      check_drained("a_make_event");
      check_row("a_make_row4", 4);
      send_frame(8'hF0, 1'b0);
      expect_key(4, 0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check_drained("a_break_event");
      check_row("a_break_row4", 4);

      // Two keys in different rows, release only one
      kb.keyrow = 4'd8;
      expect_key(8, 0, 1'b1);
      send_frame(8'h12, 1'b0);
      kb.keyrow = 4'd4;
      expect_key(4, 0, 1'b1);
      send_frame(8'h1C, 1'b0);
      check_row("shift_row8", 8);
      check_row("a_row4", 4);
      kb.keyrow = 4'd8;
      send_frame(8'hF0, 1'b0);
      expect_key(8, 0, 1'b0);
      send_frame(8'h12, 1'b0);
      check_drained("shift_break_event");
      check_row("shift_released_row8", 8);
      check_row("a_still_row4", 4);

      // Extended code maps; bare keypad code does not
      kb.keyrow = 4'd1;
      send_frame(8'hE0, 1'b0);
      expect_key(1, 0, 1'b1);
      send_frame(8'h75, 1'b0);
      check_drained("ext_up_event");
      check_row("ext_up_row1", 1);
      send_frame(8'h75, 1'b0);
      check_row("bare_75_row1", 1);

      // Partial frame abandoned by timeout, then a clean RETURN
      kb.keyrow = 4'd6;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      wait_clk(TO + 1);
      expect_key(6, 5, 1'b1);
      send_frame(8'h5A, 1'b0);
      check_drained("timeout_return_event");
      check_row("timeout_return_row6", 6);
      chk("return_row6_value", kb.keyin, 8'hDF);

      // Bad parity frame after releasing A
      kb.keyrow = 4'd4;
      send_frame(8'hF0, 1'b0);
      expect_key(4, 0, 1'b0);
      send_frame(8'h1C, 1'b0);
`ifndef PET2001_PS2_PARITY_EN
      expect_key(4, 0, 1'b1);
`endif
      send_frame(8'h1C, 1'b1);
      check_drained("bad_parity_event");
      check_row("bad_parity_row4", 4);

      // Short glitches on ps2_clk must not produce sample events
      kb.keyrow = 4'd9;
      ps2_data = 1'b0;
      for (int g = 0; g < 3; g++) begin
         ps2_clk = 1'b0;
         wait_clk(2);
         ps2_clk = 1'b1;
         wait_clk(10);
      end
      ps2_data = 1'b1;
      wait_clk(10);
      expect_key(9, 4, 1'b1);
      send_frame(8'h76, 1'b0);
      check_drained("glitch_runstop_event");
      check_row("glitch_runstop_row9", 9);
      chk("runstop_row9_value", kb.keyin, 8'hEF);

      // Typematic repeat still pulses, matrix unchanged
      expect_key(9, 4, 1'b1);
      send_frame(8'h76, 1'b0);
      check_drained("typematic_event");
      check_row("typematic_row9", 9);

      // Unpopulated row selects
      check_row("row10_unused", 10);
      check_row("row15_unused", 15);

      // Asynchronous reset with keys held
      kb.keyrow = 4'd9;
      wait_clk(2);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_reset_keyin", kb.keyin, 8'hFF);
      chk("async_reset_key_event", kb.key_event, 1'b0);
      for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(4);
      check_row("post_reset_row9", 9);
      check_row("post_reset_row1", 1);
      check_row("post_reset_row6", 6);

      // Receiver usable again after reset
      kb.keyrow = 4'd4;
      expect_key(4, 0, 1'b1);
      send_frame(8'h1C, 1'b0);
      check_drained("post_reset_event");
      check_row("post_reset_a_row4", 4);

      wait_clk(10);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
